// File: rtl/branch_resolve_bht.sv
// EX-stage branch/jump resolution with a bimodal 2-bit BHT.
// Registers a one-cycle flush/redirect on mispredict or misaligned target and trains the BHT.
module branch_resolve_bht #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [XLEN-1:0] i_if_pc,
    output logic            o_if_pred_taken,
    input  logic            i_ex_valid,
    input  logic [6:0]      i_ex_opcode,
    input  logic [2:0]      i_ex_func3,
    input  logic [XLEN-1:0] i_ex_pc,
    input  logic [XLEN-1:0] i_ex_rs1_data,
    input  logic [XLEN-1:0] i_ex_rs2_data,
    input  logic [XLEN-1:0] i_ex_imm,
    input  logic            i_ex_pred_taken,
    input  logic [XLEN-1:0] i_ex_pred_target,
    output logic            o_flush,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic            o_misalign,
    output logic [CNT_W-1:0] o_br_count,
    output logic [CNT_W-1:0] o_mispred_count
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [1:0]       bht [BHT_ENTRIES];
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;

    logic            is_branch;
    logic            is_jal;
    logic            is_jalr;
    logic            ctl;
    logic            cond_update;
    logic            cond_taken;
    logic            taken;
    logic            eff_valid;
    logic            mispredict;
    logic            misalign;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] fallthrough;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{i_if_pc[XLEN-1:IDX_W+2], i_if_pc[1:0]};

    assign if_idx          = i_if_pc[IDX_W+1:2];
    assign ex_idx          = i_ex_pc[IDX_W+1:2];
    // Fetch lookup reads the stored counter; a same-cycle update is not bypassed.
    assign o_if_pred_taken = bht[if_idx][1];

    always_comb begin
        is_branch   = (i_ex_opcode == OP_BRANCH);
        is_jal      = (i_ex_opcode == OP_JAL);
        is_jalr     = (i_ex_opcode == OP_JALR);
        ctl         = is_branch | is_jal | is_jalr;
        cond_update = is_branch & (i_ex_func3 != 3'b010) & (i_ex_func3 != 3'b011);
        cond_taken  = 1'b0;
        case (i_ex_func3)
            3'b000:  cond_taken = (i_ex_rs1_data == i_ex_rs2_data);
            3'b001:  cond_taken = (i_ex_rs1_data != i_ex_rs2_data);
            3'b100:  cond_taken = ($signed(i_ex_rs1_data) <  $signed(i_ex_rs2_data));
            3'b101:  cond_taken = ($signed(i_ex_rs1_data) >= $signed(i_ex_rs2_data));
            3'b110:  cond_taken = (i_ex_rs1_data <  i_ex_rs2_data);
            3'b111:  cond_taken = (i_ex_rs1_data >= i_ex_rs2_data);
            default: cond_taken = 1'b0;
        endcase
        taken       = is_jal | is_jalr | (is_branch & cond_taken);
        jalr_sum    = i_ex_rs1_data + i_ex_imm;
        target      = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (i_ex_pc + i_ex_imm);
        fallthrough = i_ex_pc + XLEN'(4);
        // The slot right after a flush is wrong-path.
        eff_valid   = i_ex_valid & ~o_flush;
        mispredict  = eff_valid & ctl &
                      ((taken != i_ex_pred_taken) | (taken & (target != i_ex_pred_target)));
        misalign    = eff_valid & taken & target[1];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
            o_flush         <= 1'b0;
            o_misalign      <= 1'b0;
            o_redirect_pc   <= '0;
            o_br_count      <= '0;
            o_mispred_count <= '0;
        end else begin
            o_flush    <= mispredict | misalign;
            o_misalign <= misalign;
            if (mispredict | misalign) begin
                o_redirect_pc <= taken ? target : fallthrough;
            end
            if (eff_valid & cond_update) begin
                if (taken && bht[ex_idx] != 2'b11) begin
                    bht[ex_idx] <= bht[ex_idx] + 2'b01;
                end else if (!taken && bht[ex_idx] != 2'b00) begin
                    bht[ex_idx] <= bht[ex_idx] - 2'b01;
                end
            end
            if (eff_valid && ctl && o_br_count != '1) begin
                o_br_count <= o_br_count + 1'b1;
            end
            if (mispredict && o_mispred_count != '1) begin
                o_mispred_count <= o_mispred_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_branch_resolve_bht.sv
// Bench for branch_resolve_bht: directed cases with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_branch_resolve_bht;
    localparam int XLEN  = 32;
    localparam int NENT  = 64;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_ALU  = 7'b0110011;

    logic             clk;
    logic             rst_n;
    logic [XLEN-1:0]  if_pc;
    logic             if_pred_taken;
    logic             ex_valid;
    logic [6:0]       ex_opcode;
    logic [2:0]       ex_func3;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_rs1;
    logic [XLEN-1:0]  ex_rs2;
    logic [XLEN-1:0]  ex_imm;
    logic             ex_pred_taken;
    logic [XLEN-1:0]  ex_pred_target;
    logic             flush;
    logic [XLEN-1:0]  redirect_pc;
    logic             misalign;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mispred_count;

    branch_resolve_bht #(.XLEN(XLEN), .BHT_ENTRIES(NENT), .CNT_W(CNT_W)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_if_pc          (if_pc),
        .o_if_pred_taken  (if_pred_taken),
        .i_ex_valid       (ex_valid),
        .i_ex_opcode      (ex_opcode),
        .i_ex_func3       (ex_func3),
        .i_ex_pc          (ex_pc),
        .i_ex_rs1_data    (ex_rs1),
        .i_ex_rs2_data    (ex_rs2),
        .i_ex_imm         (ex_imm),
        .i_ex_pred_taken  (ex_pred_taken),
        .i_ex_pred_target (ex_pred_target),
        .o_flush          (flush),
        .o_redirect_pc    (redirect_pc),
        .o_misalign       (misalign),
        .o_br_count       (br_count),
        .o_mispred_count  (mispred_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural model state
    int          m_bht [NENT];
    bit          m_flush;
    bit          m_misalign;
    logic [31:0] m_redirect;
    int          m_br;
    int          m_mis;
    bit          started;

    int n_cmp;
    int n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void resolve(input logic [6:0] op, input logic [2:0] f3,
                                    input logic [31:0] pc, input logic [31:0] rs1,
                                    input logic [31:0] rs2, input logic [31:0] imm,
                                    output bit ctl, output bit taken, output bit upd,
                                    output logic [31:0] tgt);
        longint sa, sb;
        sa    = longint'($signed(rs1));
        sb    = longint'($signed(rs2));
        ctl   = (op == OP_BR) || (op == OP_JAL) || (op == OP_JALR);
        upd   = (op == OP_BR) && (f3 != 3'd2) && (f3 != 3'd3);
        taken = (op == OP_JAL) || (op == OP_JALR);
        if (op == OP_BR) begin
            if (f3 == 3'd0) taken = (rs1 == rs2);
            if (f3 == 3'd1) taken = (rs1 != rs2);
            if (f3 == 3'd4) taken = (sa < sb);
            if (f3 == 3'd5) taken = (sa >= sb);
            if (f3 == 3'd6) taken = (longint'(rs1) < longint'(rs2));
            if (f3 == 3'd7) taken = (longint'(rs1) >= longint'(rs2));
        end
        if (op == OP_JALR) tgt = 32'((longint'(rs1) + longint'(imm)) % 64'h1_0000_0000) & 32'hFFFF_FFFE;
        else               tgt = 32'((longint'(pc) + longint'(imm)) % 64'h1_0000_0000);
    endfunction

    always @(posedge clk) begin
        bit          ctl, taken, upd, eff, mis, mal;
        logic [31:0] tgt;
        int          idx;
        started = 1'b1;
        if (!rst_n) begin
            for (int i = 0; i < NENT; i++) m_bht[i] = 1;
            m_flush    = 1'b0;
            m_misalign = 1'b0;
            m_redirect = 32'd0;
            m_br       = 0;
            m_mis      = 0;
        end else begin
            resolve(ex_opcode, ex_func3, ex_pc, ex_rs1, ex_rs2, ex_imm, ctl, taken, upd, tgt);
            eff = ex_valid && !m_flush;
            mis = eff && ctl && ((taken != ex_pred_taken) || (taken && tgt != ex_pred_target));
            mal = eff && ctl && taken && (tgt % 4 >= 2);
            if (mis || mal) m_redirect = taken ? tgt : ex_pc + 32'd4;
            m_flush    = mis || mal;
            m_misalign = mal;
            idx = int'((ex_pc / 4) % NENT);
            if (eff && upd) begin
                if (taken) m_bht[idx] = (m_bht[idx] < 3) ? m_bht[idx] + 1 : 3;
                else       m_bht[idx] = (m_bht[idx] > 0) ? m_bht[idx] - 1 : 0;
            end
            if (eff && ctl && m_br < CMAX) m_br++;
            if (mis && m_mis < CMAX) m_mis++;
        end
    end

    // compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        if (started) begin
            chk("flush",     32'(flush),         32'(m_flush));
            chk("misalign",  32'(misalign),      32'(m_misalign));
            chk("redirect",  redirect_pc,        m_redirect);
            chk("br_count",  32'(br_count),      32'(m_br));
            chk("mis_count", 32'(mispred_count), 32'(m_mis));
            chk("pred",      32'(if_pred_taken), 32'(m_bht[int'((if_pc / 4) % NENT)] / 2));
        end
    end

    // driver tasks
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic pt, input logic [31:0] ptgt);
        ex_valid       = v;
        ex_opcode      = op;
        ex_func3       = f3;
        ex_pc          = pc;
        ex_rs1         = rs1;
        ex_rs2         = rs2;
        ex_imm         = imm;
        ex_pred_taken  = pt;
        ex_pred_target = ptgt;
    endtask

    task automatic idle();
        drive(1'b0, OP_ALU, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    endtask

    initial begin
        bit          ctl, taken, upd;
        logic [31:0] tgt;
        logic [6:0]  op;
        logic [31:0] pc, rs1, rs2, imm;
        n_cmp   = 0;
        n_fail  = 0;
        started = 1'b0;
        rst_n   = 1'b0;
        if_pc   = 32'h100;
        idle();
        tick();
        tick();
        // reset state
        chk("rst_pred",  32'(if_pred_taken), 32'd0);
        chk("rst_flush", 32'(flush),         32'd0);
        chk("rst_br",    32'(br_count),      32'd0);
        chk("rst_mis",   32'(mispred_count), 32'd0);
        rst_n = 1'b1;

        // BEQ taken, predicted not-taken
        drive(1'b1, OP_BR, 3'd0, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0, 32'd0);
        tick();
        chk("beq_flush",    32'(flush),         32'd1);
        chk("beq_redirect", redirect_pc,        32'h120);
        chk("beq_mis",      32'(mispred_count), 32'd1);
        chk("beq_bht",      32'(if_pred_taken), 32'd1);
        idle();
        tick();
        chk("beq_pulse",    32'(flush),         32'd0);

        // BLTU not taken, BLT taken on the same operands
        drive(1'b1, OP_BR, 3'd6, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0, 32'd0);
        tick();
        chk("bltu_flush", 32'(flush), 32'd0);
        drive(1'b1, OP_BR, 3'd4, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0, 32'd0);
        tick();
        chk("blt_flush",    32'(flush),  32'd1);
        chk("blt_redirect", redirect_pc, 32'h240);
        idle();
        tick();

        // JALR with wrong predicted target lands on a misaligned target
        drive(1'b1, OP_JALR, 3'd0, 32'h300, 32'h203, 32'd0, 32'd4, 1'b1, 32'h200);
        tick();
        chk("jalr_flush",    32'(flush),    32'd1);
        chk("jalr_redirect", redirect_pc,   32'h206);
        chk("jalr_misalign", 32'(misalign), 32'd1);
        idle();
        tick();

        // BHT saturation at one PC
        if_pc = 32'h340;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, OP_BR, 3'd0, 32'h340, 32'd1, 32'd1, 32'h10, 1'b1, 32'h350);
            tick();
            chk("sat_up", 32'(if_pred_taken), 32'd1);
            idle();
            tick();
        end
        drive(1'b1, OP_BR, 3'd1, 32'h340, 32'd1, 32'd1, 32'h10, 1'b0, 32'd0);
        tick();
        chk("sat_dn1", 32'(if_pred_taken), 32'd1);
        drive(1'b1, OP_BR, 3'd1, 32'h340, 32'd1, 32'd1, 32'h10, 1'b0, 32'd0);
        tick();
        chk("sat_dn2", 32'(if_pred_taken), 32'd0);

        // wrong-path slot after a flush is ignored
        drive(1'b1, OP_BR, 3'd0, 32'h400, 32'd0, 32'd0, 32'h8, 1'b0, 32'd0);
        tick();
        chk("wp_flush", 32'(flush), 32'd1);
        drive(1'b1, OP_JAL, 3'd0, 32'h500, 32'd0, 32'd0, 32'h10, 1'b0, 32'd0);
        tick();
        chk("wp_noflush", 32'(flush), 32'd0);
        // reset during a mispredicting resolve drops the flush
        drive(1'b1, OP_BR, 3'd0, 32'h400, 32'd0, 32'd0, 32'h8, 1'b0, 32'd0);
        rst_n = 1'b0;
        tick();
        chk("rstmid_flush", 32'(flush),    32'd0);
        chk("rstmid_br",    32'(br_count), 32'd0);
        rst_n = 1'b1;
        idle();
        tick();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            case ($urandom_range(0, 5))
                0, 1, 2: op = OP_BR;
                3:       op = OP_JAL;
                4:       op = OP_JALR;
                default: op = OP_ALU;
            endcase
            pc  = (32'($urandom_range(0, 15)) << 2) + (32'($urandom_range(0, 3)) << 8);
            if ($urandom_range(0, 7) == 0) pc = pc | 32'hFFFF_FF00;
            rs1 = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 3)) - 32'd1;
            rs2 = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 3)) - 32'd1;
            imm = 32'($urandom_range(0, 64)) * 32'd2;
            if ($urandom_range(0, 1) == 1) imm = -imm;
            resolve(op, 3'($urandom_range(0, 7)), pc, rs1, rs2, imm, ctl, taken, upd, tgt);
            drive(($urandom_range(0, 3) != 0), op, 3'($urandom_range(0, 7)), pc, rs1, rs2, imm,
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) == 1) ? tgt : $urandom());
            if_pc = (32'($urandom_range(0, 15)) << 2) + (32'($urandom_range(0, 3)) << 8);
            tick();
        end

        idle();
        rst_n = 1'b1;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
